// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder constants, traceback FSM state type and trellis helper.
package viterbi_pkg;

    localparam int NUM_STATES = 8;
    localparam int STATE_W    = 3;
    localparam int TB_LEN     = 16;
    localparam int IDX_W      = 4;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_TRACE = 2'd1,
        ST_EMIT  = 2'd2
    } tb_fsm_e;

    // Step one column back in time: the oldest register bit is recovered from the survivor bit.
    function automatic logic [STATE_W-1:0] prev_trellis_state(
        input logic [STATE_W-1:0] cur,
        input logic               surv
    );
        return {cur[STATE_W-2:0], surv};
    endfunction

endpackage

// File: rtl/tb_survivor_mem.sv
// Survivor column store: 16 columns of per-state ACS selection bits, sync write, async read.
module tb_survivor_mem
    import viterbi_pkg::*;
(
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      wr_addr,
    input  logic [NUM_STATES-1:0] wr_data,
    input  logic [IDX_W-1:0]      rd_addr,
    output logic [NUM_STATES-1:0] rd_data
);

    logic [NUM_STATES-1:0] mem_r [TB_LEN];

    // Column write; contents are don't-care until a full block has been written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/survivor_traceback.sv
// Block traceback unit: fill 16 survivor columns, trace back 16 steps, emit bits oldest first.
// Optional macro TB_BEST_STATE_EN: start traceback from start_state instead of state 0.
module survivor_traceback
    import viterbi_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NUM_STATES-1:0] sel_in,
    input  logic [STATE_W-1:0]    start_state,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_bit
);

    tb_fsm_e               state_r;
    tb_fsm_e               next_state_s;
    logic [IDX_W-1:0]      wr_idx_r;
    logic [IDX_W-1:0]      rd_idx_r;
    logic [IDX_W-1:0]      rd_next_s;
    logic [IDX_W-1:0]      col_idx_s;
    logic [STATE_W-1:0]    cur_state_r;
    logic [STATE_W-1:0]    start_s;
    logic [TB_LEN-1:0]     out_reg_r;
    logic [NUM_STATES-1:0] sel_col_s;
    logic                  in_ready_r;
    logic                  out_valid_r;
    logic                  out_bit_r;
    logic                  accept_s;
    logic                  last_col_s;
    logic                  tracing_s;
    logic                  trace_last_s;
    logic                  emit_hs_s;
    logic                  last_bit_s;
    logic                  dec_bit_s;
    logic                  surv_bit_s;

`ifdef TB_BEST_STATE_EN
    assign start_s = start_state;
`else
    logic start_unused_s;
    assign start_unused_s = ^start_state;
    assign start_s        = {STATE_W{1'b0}};
`endif

    // During TRACE wr_idx counts back down to 0, so the column being traced is wr_idx-1.
    assign col_idx_s    = wr_idx_r - 4'd1;
    assign rd_next_s    = rd_idx_r + 4'd1;
    assign accept_s     = in_valid & in_ready_r;
    assign last_col_s   = accept_s & (wr_idx_r == 4'd15);
    assign tracing_s    = (state_r == ST_TRACE);
    assign trace_last_s = tracing_s & (wr_idx_r == 4'd1);
    assign emit_hs_s    = out_valid_r & out_ready;
    assign last_bit_s   = emit_hs_s & (rd_idx_r == 4'd15);
    assign dec_bit_s    = cur_state_r[STATE_W-1];
    assign surv_bit_s   = sel_col_s[cur_state_r];

    tb_survivor_mem u_mem (
        .clk     (clk),
        .we      (accept_s),
        .wr_addr (wr_idx_r),
        .wr_data (sel_in),
        .rd_addr (col_idx_s),
        .rd_data (sel_col_s)
    );

    // Next-state decode for the FILL -> TRACE -> EMIT block cycle.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_FILL:  if (last_col_s)   next_state_s = ST_TRACE; else next_state_s = ST_FILL;
            ST_TRACE: if (trace_last_s) next_state_s = ST_EMIT;  else next_state_s = ST_TRACE;
            ST_EMIT:  if (last_bit_s)   next_state_s = ST_FILL;  else next_state_s = ST_EMIT;
            default:  next_state_s = ST_FILL;
        endcase
    end

    // Control registers; handshake flags are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_FILL;
            wr_idx_r    <= 4'd0;
            rd_idx_r    <= 4'd0;
            cur_state_r <= 3'd0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_bit_r   <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            in_ready_r  <= (next_state_s == ST_FILL);
            out_valid_r <= (next_state_s == ST_EMIT);
            if (accept_s) begin
                wr_idx_r <= wr_idx_r + 4'd1;
            end else if (tracing_s) begin
                wr_idx_r <= col_idx_s;
            end
            if (last_col_s) begin
                cur_state_r <= start_s;
            end else if (tracing_s) begin
                cur_state_r <= prev_trellis_state(cur_state_r, surv_bit_s);
            end
            if (emit_hs_s) begin
                rd_idx_r <= rd_next_s;
            end
            // Column 0 is decoded in the last TRACE cycle, so present it directly.
            if (trace_last_s) begin
                out_bit_r <= dec_bit_s;
            end else if (emit_hs_s) begin
                out_bit_r <= out_reg_r[rd_next_s];
            end
        end
    end

    // Decoded bits land at their column position; no reset needed.
    always_ff @(posedge clk) begin
        if (tracing_s) begin
            out_reg_r[col_idx_s] <= dec_bit_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_bit   = out_bit_r;

endmodule

// File: tb/tb_survivor_traceback.sv
// Directed bench for survivor_traceback: latency, decode, backpressure, ignored input, reset.
module tb_survivor_traceback;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] sel_in;
    logic [2:0] start_state;
    logic       out_valid;
    logic       out_ready;
    logic       out_bit;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    survivor_traceback dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .sel_in      (sel_in),
        .start_state (start_state),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bit     (out_bit)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Forward encoder model: state s' = {u, s[2:1]}; survivor bit of s' is the dropped s[0].
    function automatic logic [127:0] encode_cols(input logic [15:0] seq);
        logic [2:0]   s;
        logic [2:0]   sn;
        logic [127:0] cols;
        s    = 3'd0;
        cols = '0;
        for (int t = 0; t < 16; t++) begin
            sn = {seq[t], s[2:1]};
            cols[t*8 + int'(sn)] = s[0];
            s = sn;
        end
        return cols;
    endfunction

    task automatic send_block(input logic [127:0] cols, input logic [2:0] st);
        for (int i = 0; i < 16; i++) begin
            int guard;
            guard = 0;
            @(negedge clk);
            while (!in_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (!in_ready) check_eq("fill_ready_timeout", 32'(in_ready), 32'd1);
            in_valid    = 1'b1;
            sel_in      = cols[i*8 +: 8];
            start_state = st;
        end
    endtask

    task automatic collect(input string tag, input bit garbage, input bit stall,
                           output logic [15:0] bits, output int lat);
        logic hold;
        logic valid_ok;
        lat      = 0;
        bits     = 16'd0;
        valid_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            in_valid = garbage;
            sel_in   = garbage ? 8'hFF : 8'h00;
        end while (!out_valid && lat < 100);
        if (!out_valid) begin
            check_eq({tag, "_valid_timeout"}, 32'(out_valid), 32'd1);
            in_valid = 1'b0;
            return;
        end
        for (int i = 0; i < 16; i++) begin
            if (stall && i == 3) begin
                hold      = out_bit;
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check_eq({tag, "_stall_hold"}, 32'(out_bit), 32'(hold));
                end
                out_ready = 1'b1;
            end
            if (!out_valid) valid_ok = 1'b0;
            bits[i] = out_bit;
            @(negedge clk);
        end
        check_eq({tag, "_valid_thru"}, 32'(valid_ok), 32'd1);
        in_valid = 1'b0;
        check_eq({tag, "_done_ready"}, 32'(in_ready), 32'd1);
        check_eq({tag, "_done_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [15:0] bits;
        int          lat;
        logic        stale;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        sel_in      = 8'h00;
        start_state = 3'd0;
        out_ready   = 1'b1;

        repeat (2) @(negedge clk);
        check_eq("rst_in_ready",  32'(in_ready),  32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_bit",   32'(out_bit),   32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("rel_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        check_eq("rel_ready_one_edge", 32'(in_ready), 32'd1);

        // All-zero survivors from state 0: all zero bits, 17-cycle latency.
        send_block(128'd0, 3'd0);
        collect("zero", 1'b0, 1'b0, bits, lat);
        check_eq("zero_bits", 32'(bits), 32'h0000);
        check_eq("zero_latency", 32'(lat), 32'd17);

        // Encoded sequence 1,0,1,1,0,0,1,0,1,1,1,0,0,0,0,0 (bit i = i-th input).
        send_block(encode_cols(16'h074D), 3'd0);
        collect("seq", 1'b0, 1'b0, bits, lat);
        check_eq("seq_bits", 32'(bits), 32'h074D);
        check_eq("seq_latency", 32'(lat), 32'd17);

        // Consumer stall at bit 3.
        send_block(encode_cols(16'h074D), 3'd0);
        collect("stall", 1'b0, 1'b1, bits, lat);
        check_eq("stall_bits", 32'(bits), 32'h074D);

        // in_valid held with junk through TRACE/EMIT, then a fresh block must align at column 0.
        send_block(encode_cols(16'h074D), 3'd0);
        collect("junk", 1'b1, 1'b0, bits, lat);
        check_eq("junk_bits", 32'(bits), 32'h074D);
        send_block(encode_cols(16'h1C63), 3'd0);
        collect("after_junk", 1'b0, 1'b0, bits, lat);
        check_eq("after_junk_bits", 32'(bits), 32'h1C63);

        // All-ones survivors with start_state 5.
        send_block({16{8'hFF}}, 3'd5);
        collect("best", 1'b0, 1'b0, bits, lat);
`ifdef TB_BEST_STATE_EN
        check_eq("best_bits", 32'(bits), 32'hBFFF);
`else
        check_eq("best_bits", 32'(bits), 32'h1FFF);
`endif

        // Reset during TRACE cycle 5: partial block discarded, no stale output.
        send_block(encode_cols(16'h074D), 3'd0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_in_ready",  32'(in_ready),  32'd0);
        @(negedge clk);
        check_eq("midrst_hold_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_hold_ready", 32'(in_ready),  32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("midrst_rel_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        check_eq("midrst_rel_ready", 32'(in_ready), 32'd1);
        stale = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        check_eq("midrst_no_stale", 32'(stale), 32'd0);
        send_block(encode_cols(16'h1C63), 3'd0);
        collect("post_rst", 1'b0, 1'b0, bits, lat);
        check_eq("post_rst_bits", 32'(bits), 32'h1C63);
        check_eq("post_rst_latency", 32'(lat), 32'd17);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
